// File: rtl/hazard_control_unit.sv
// Pipeline hazard/stall/flush controller with run-halt-step FSM
// and saturating stall/flush event counters.
module hazard_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        inMemReadEX,
  input  logic [4:0]  inRegRtEX,
  input  logic [4:0]  inRegRsID,
  input  logic [4:0]  inRegRtID,
  input  logic        inUsesRtID,
  input  logic        inBranchTakenMEM,
  input  logic        inRun,
  input  logic        stepReq,
  input  logic        clrCounters,
  output logic        pcEnable,
  output logic        ifIdEnable,
  output logic        idExEnable,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        exMemFlush,
  output logic        stepAck,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } state_t;

  state_t cur;
  state_t nxt;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic active;
  logic flush_evt;
  logic stall_evt;
  logic idle_evt;

  assign rs_hit = (inRegRtEX == inRegRsID);
  assign rt_hit = inUsesRtID &&
                  (inRegRtEX == inRegRtID);

  assign load_use = inMemReadEX &&
                    (inRegRtEX != 5'd0) &&
                    (rs_hit || rt_hit);

  // Outputs are forced quiet while reset is held.
  assign active = !reset &&
                  ((cur == RUN) || (cur == STEP));

  assign flush_evt = active && inBranchTakenMEM;
  assign stall_evt = active && !inBranchTakenMEM &&
                     load_use;
  assign idle_evt  = active && !inBranchTakenMEM &&
                     !load_use;

  always_comb begin
    pcEnable   = 1'b0;
    ifIdEnable = 1'b0;
    idExEnable = 1'b0;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    exMemFlush = 1'b0;
    unique case (1'b1)
      flush_evt: begin
        pcEnable   = 1'b1;
        ifIdEnable = 1'b1;
        idExEnable = 1'b1;
        ifIdFlush  = 1'b1;
        idExFlush  = 1'b1;
        exMemFlush = 1'b1;
      end
      stall_evt: begin
        idExEnable = 1'b1;
        idExFlush  = 1'b1;
      end
      idle_evt: begin
        pcEnable   = 1'b1;
        ifIdEnable = 1'b1;
        idExEnable = 1'b1;
      end
      default: begin
        pcEnable   = 1'b0;
      end
    endcase
  end

  assign stepAck = !reset && (cur == STEP);

  // Run request wins over a step request from HALT.
  always_comb begin
    nxt = cur;
    unique case (cur)
      RUN:  nxt = inRun ? RUN : HALT;
      HALT: begin
        if (inRun)
          nxt = RUN;
        else if (stepReq)
          nxt = STEP;
        else
          nxt = HALT;
      end
      STEP: nxt = inRun ? RUN : HALT;
      default: nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cur <= RUN;
    else
      cur <= nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= 16'd0;
      flushCount <= 16'd0;
    end else if (clrCounters) begin
      stallCount <= 16'd0;
      flushCount <= 16'd0;
    end else begin
      if (stall_evt && (stallCount != 16'hFFFF))
        stallCount <= stallCount + 16'd1;
      if (flush_evt && (flushCount != 16'hFFFF))
        flushCount <= flushCount + 16'd1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table,
// directed halt/step/saturation/reset sequences, random vs model.
module tb_hazard_control_unit;

  logic        clk;
  logic        reset;
  logic        inMemReadEX;
  logic [4:0]  inRegRtEX;
  logic [4:0]  inRegRsID;
  logic [4:0]  inRegRtID;
  logic        inUsesRtID;
  logic        inBranchTakenMEM;
  logic        inRun;
  logic        stepReq;
  logic        clrCounters;
  logic        pcEnable;
  logic        ifIdEnable;
  logic        idExEnable;
  logic        ifIdFlush;
  logic        idExFlush;
  logic        exMemFlush;
  logic        stepAck;
  logic [15:0] stallCount;
  logic [15:0] flushCount;
  logic [1:0]  state;

  hazard_control_unit dut (
    .clk(clk),
    .reset(reset),
    .inMemReadEX(inMemReadEX),
    .inRegRtEX(inRegRtEX),
    .inRegRsID(inRegRsID),
    .inRegRtID(inRegRtID),
    .inUsesRtID(inUsesRtID),
    .inBranchTakenMEM(inBranchTakenMEM),
    .inRun(inRun),
    .stepReq(stepReq),
    .clrCounters(clrCounters),
    .pcEnable(pcEnable),
    .ifIdEnable(ifIdEnable),
    .idExEnable(idExEnable),
    .ifIdFlush(ifIdFlush),
    .idExFlush(idExFlush),
    .exMemFlush(exMemFlush),
    .stepAck(stepAck),
    .stallCount(stallCount),
    .flushCount(flushCount),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Model: 0 = RUN, 1 = HALT, 2 = STEP
  int m_state;
  int m_stall;
  int m_flush;

  typedef struct {
    logic       mr;
    logic [4:0] rtex;
    logic [4:0] rsid;
    logic [4:0] rtid;
    logic       uses;
    logic       br;
    logic [2:0] en;
    logic [2:0] fl;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic mr,
                       input logic [4:0] rtex,
                       input logic [4:0] rsid,
                       input logic [4:0] rtid,
                       input logic uses,
                       input logic br,
                       input logic run,
                       input logic stp,
                       input logic clr);
    inMemReadEX      = mr;
    inRegRtEX        = rtex;
    inRegRsID        = rsid;
    inRegRtID        = rtid;
    inUsesRtID       = uses;
    inBranchTakenMEM = br;
    inRun            = run;
    stepReq          = stp;
    clrCounters      = clr;
  endtask

  function automatic bit model_lu();
    int rt;
    rt = int'(inRegRtEX);
    if (!inMemReadEX || rt == 0) return 1'b0;
    if (rt == int'(inRegRsID)) return 1'b1;
    if (inUsesRtID && rt == int'(inRegRtID))
      return 1'b1;
    return 1'b0;
  endfunction

  // {pc, ifid, idex, ifflush, idexflush, exmemflush, ack}
  function automatic logic [6:0] model_out();
    logic ack;
    if (m_state == 1) return 7'd0;
    ack = (m_state == 2);
    if (inBranchTakenMEM) return {6'b111111, ack};
    if (model_lu()) return {6'b001010, ack};
    return {6'b111000, ack};
  endfunction

  function automatic logic [6:0] dut_out();
    return {pcEnable, ifIdEnable, idExEnable,
            ifIdFlush, idExFlush, exMemFlush,
            stepAck};
  endfunction

  task automatic check_comb(input string name);
    #2;
    chk(name, 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic tick();
    bit act;
    bit lu;
    int ns;
    act = (m_state != 1);
    lu  = model_lu();
    case (m_state)
      0: ns = inRun ? 0 : 1;
      1: ns = inRun ? 0 : (stepReq ? 2 : 1);
      default: ns = inRun ? 0 : 1;
    endcase
    @(posedge clk);
    #1;
    if (clrCounters) begin
      m_stall = 0;
      m_flush = 0;
    end else if (act && inBranchTakenMEM) begin
      if (m_flush < 65535) m_flush++;
    end else if (act && lu) begin
      if (m_stall < 65535) m_stall++;
    end
    m_state = ns;
    chk("state", 32'(state), 32'(m_state));
    chk("stallCount", 32'(stallCount), 32'(m_stall));
    chk("flushCount", 32'(flushCount), 32'(m_flush));
  endtask

  task automatic check_reset_quiet(input string name);
    chk({name, "_out"}, 32'(dut_out()), 32'd0);
    chk({name, "_state"}, 32'(state), 32'd0);
    chk({name, "_stall"}, 32'(stallCount), 32'd0);
    chk({name, "_flush"}, 32'(flushCount), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    vt[0] = '{0, 5'd5,  5'd5,  5'd0,  0, 0, 3'b111, 3'b000};
    vt[1] = '{1, 5'd5,  5'd5,  5'd0,  0, 0, 3'b001, 3'b010};
    vt[2] = '{1, 5'd0,  5'd0,  5'd0,  1, 0, 3'b111, 3'b000};
    vt[3] = '{1, 5'd7,  5'd3,  5'd7,  1, 0, 3'b001, 3'b010};
    vt[4] = '{1, 5'd7,  5'd3,  5'd7,  0, 0, 3'b111, 3'b000};
    vt[5] = '{1, 5'd9,  5'd4,  5'd2,  1, 0, 3'b111, 3'b000};
    vt[6] = '{1, 5'd5,  5'd5,  5'd5,  1, 1, 3'b111, 3'b111};
    vt[7] = '{0, 5'd1,  5'd2,  5'd3,  0, 1, 3'b111, 3'b111};
    vt[8] = '{1, 5'd31, 5'd31, 5'd0,  0, 0, 3'b001, 3'b010};
    vt[9] = '{1, 5'd0,  5'd8,  5'd0,  1, 0, 3'b111, 3'b000};

    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    #1;
    check_reset_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_state = 0;
    m_stall = 0;
    m_flush = 0;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].mr, vt[i].rtex, vt[i].rsid,
            vt[i].rtid, vt[i].uses, vt[i].br,
            1, 0, 0);
      #2;
      chk($sformatf("vec%0d_en", i),
          32'({pcEnable, ifIdEnable, idExEnable}),
          32'(vt[i].en));
      chk($sformatf("vec%0d_fl", i),
          32'({ifIdFlush, idExFlush, exMemFlush}),
          32'(vt[i].fl));
      tick();
    end

    // Halt with a live hazard, then single steps.
    drive(1, 5, 5, 0, 0, 0, 0, 0, 0);
    tick();
    chk("halt_state", 32'(state), 32'd1);
    check_comb("halt_quiet");
    drive(1, 5, 5, 0, 0, 1, 0, 0, 0);
    check_comb("halt_branch_quiet");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    chk("step_state", 32'(state), 32'd2);
    check_comb("step_out");
    chk("step_ack", 32'(stepAck), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("step_back", 32'(state), 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      check_comb("step_held");
      tick();
      chk("step_alt", 32'(state),
          (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    chk("run_prio", 32'(state), 32'd0);

    // Saturation then clear with a hazard present.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
    tick();
    drive(1, 5, 5, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 65536; i++) @(posedge clk);
    #1;
    m_stall = 65535;
    chk("sat_stall", 32'(stallCount), 32'hFFFF);
    check_comb("sat_out");
    tick();
    chk("sat_hold", 32'(stallCount), 32'hFFFF);
    drive(1, 5, 5, 0, 0, 1, 1, 0, 1);
    tick();
    chk("clr_stall", 32'(stallCount), 32'd0);
    chk("clr_flush", 32'(flushCount), 32'd0);

    // Reset in the middle of a step.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 3, 3, 0, 0, 0, 0, 1, 0);
    tick();
    chk("pre_rst_step", 32'(state), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_reset_quiet("async_rst");
    @(posedge clk);
    #2;
    check_reset_quiet("rst_held");
    reset = 1'b0;
    m_state = 0;
    m_stall = 0;
    m_flush = 0;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check_comb("post_rst");
    chk("post_rst_ack", 32'(stepAck), 32'd0);
    tick();
    chk("post_rst_run", 32'(state), 32'd0);

    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 3) != 0,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0);
      check_comb("rand_out");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
